iob_eth_rx_seq: RTL

//  Hardware RX sequencer for iob_eth. Master on the iob_eth CPU-side native bus: polls STATUS for RX-ready,

---
 rtl/iob_eth_rx_seq.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_rx_seq.sv
`default_nettype none
// ============================================================================
//  Module   : iob_eth_rx_seq
//  Brief    : Hardware RX sequencer for iob_eth. Polls STATUS for a received
//             frame, reads it byte-by-byte from the RX buffer window over the
//             native bus, streams the bytes out and acknowledges with RCVACK.
//  Revision : 1.0 - initial release
// ============================================================================
module iob_eth_rx_seq #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned LEN_W        = 11,
    parameter int unsigned STATUS_ADDR  = 0,
    parameter int unsigned RCVACK_ADDR  = 0,
    parameter int unsigned DATA_RD_ADDR = 0,
    parameter int unsigned RX_RDY_BIT   = 1,
    parameter int unsigned POLL_GAP     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_address,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready,
    output logic [7:0]        rx_tdata,
    output logic              rx_tvalid,
    output logic              rx_tlast,
    input  logic              rx_tready,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned BA_W  = ADDR_W + 2;
    localparam int unsigned GAP_W = 16;

    // Fixed bus targets, split into word address and byte lane
    localparam logic [ADDR_W-1:0] c_status_word = ADDR_W'(STATUS_ADDR >> 2);
    localparam logic [1:0]        c_status_lane = 2'(STATUS_ADDR % 4);
    localparam logic [ADDR_W-1:0] c_ack_word    = ADDR_W'(RCVACK_ADDR >> 2);
    localparam logic [1:0]        c_ack_lane    = 2'(RCVACK_ADDR % 4);
    localparam logic [1:0]        c_data_lane   = 2'(DATA_RD_ADDR % 4);
    localparam logic [BA_W-1:0]   c_data_baddr  = BA_W'(DATA_RD_ADDR);
    localparam logic [3:0]        c_ack_strb    = 4'b0001 << c_ack_lane;
    localparam logic [31:0]       c_ack_data    = 32'd1 << {c_ack_lane, 3'b000};
    localparam logic [GAP_W-1:0]  c_gap_last    = GAP_W'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POLL = 3'd1,
        S_GAP  = 3'd2,
        S_READ = 3'd3,
        S_PUSH = 3'd4,
        S_ACK  = 3'd5
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [GAP_W-1:0]  r_gap;
    logic              r_m_valid;
    logic [ADDR_W-1:0] r_m_address;
    logic [31:0]       r_m_wdata;
    logic [3:0]        r_m_wstrb;
    logic [7:0]        r_byte;
    logic              r_tvalid;
    logic              r_tlast;
    logic [15:0]       r_frame_cnt;

    // Byte selected from a 32-bit read word by its lane
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        lane_byte = 8'(word >> {lane, 3'b000});
    endfunction

    // Word address of RX buffer byte idx (full-width byte add, then drop lane)
    function automatic logic [ADDR_W-1:0] rd_word(input logic [LEN_W-1:0] idx);
        rd_word = ADDR_W'((c_data_baddr + BA_W'(idx)) >> 2);
    endfunction

    logic              w_xfer;
    logic [7:0]        w_status_byte;
    logic              w_rx_rdy;
    logic [1:0]        w_cur_lane;
    logic [7:0]        w_data_byte;
    logic [LEN_W-1:0]  w_idx_next;
    logic              w_is_last;

    assign w_xfer        = r_m_valid & m_ready;
    assign w_status_byte = lane_byte(m_rdata, c_status_lane);
    assign w_rx_rdy      = w_status_byte[3'(RX_RDY_BIT)];
    assign w_cur_lane    = c_data_lane + r_idx[1:0];
    assign w_data_byte   = lane_byte(m_rdata, w_cur_lane);
    assign w_idx_next    = r_idx + LEN_W'(1);
    assign w_is_last     = (r_idx == r_len - LEN_W'(1));

    // Sequencer FSM: bus master, stream source and frame counter in one block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_gap       <= '0;
            r_m_valid   <= 1'b0;
            r_m_address <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
            r_byte      <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state     <= S_POLL;
                        r_m_valid   <= 1'b1;
                        r_m_address <= c_status_word;
                    end
                end
                S_POLL: begin
                    if (w_xfer) begin
                        r_m_valid <= 1'b0;
                        if (w_rx_rdy) begin
                            // frame_len is only sampled here; later changes wait for the next frame
                            r_len <= frame_len;
                            r_idx <= '0;
                            if (frame_len == '0) begin
                                r_state     <= S_ACK;
                                r_m_valid   <= 1'b1;
                                r_m_address <= c_ack_word;
                                r_m_wstrb   <= c_ack_strb;
                                r_m_wdata   <= c_ack_data;
                            end else begin
                                r_state     <= S_READ;
                                r_m_valid   <= 1'b1;
                                r_m_address <= rd_word('0);
                            end
                        end else begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == c_gap_last) begin
                        if (enable) begin
                            r_state     <= S_POLL;
                            r_m_valid   <= 1'b1;
                            r_m_address <= c_status_word;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_READ: begin
                    if (w_xfer) begin
                        r_m_valid <= 1'b0;
                        r_byte    <= w_data_byte;
                        r_tvalid  <= 1'b1;
                        r_tlast   <= w_is_last;
                        r_state   <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    // Byte and flags stay put until the consumer takes them
                    if (rx_tready) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        if (r_tlast) begin
                            r_state     <= S_ACK;
                            r_m_valid   <= 1'b1;
                            r_m_address <= c_ack_word;
                            r_m_wstrb   <= c_ack_strb;
                            r_m_wdata   <= c_ack_data;
                        end else begin
                            r_idx       <= w_idx_next;
                            r_state     <= S_READ;
                            r_m_valid   <= 1'b1;
                            r_m_address <= rd_word(w_idx_next);
                        end
                    end
                end
                S_ACK: begin
                    if (w_xfer) begin
                        r_m_valid   <= 1'b0;
                        r_m_wstrb   <= '0;
                        r_m_wdata   <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_state     <= S_GAP;
                        r_gap       <= '0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_m_valid <= 1'b0;
                    r_tvalid  <= 1'b0;
                    r_tlast   <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid   = r_m_valid;
    assign m_address = r_m_address;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign rx_tdata  = r_byte;
    assign rx_tvalid = r_tvalid;
    assign rx_tlast  = r_tlast;
    assign busy      = (r_state != S_IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
